// File: rtl/miriscv_lsu_ctrl_if.sv
// Data memory bus between the LSU sequencer (master) and the data memory port (slave).
interface miriscv_lsu_ctrl_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/miriscv_lsu_ctrl.sv
// Load/store sequencer: req/gnt/rvalid handshake, byte lanes, store replication, load extension.
// Define MIRISCV_LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module miriscv_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  input  logic               lsu_req_i,
  input  logic               lsu_we_i,
  input  logic [2:0]         lsu_size_i,
  input  logic [31:0]        lsu_addr_i,
  input  logic [31:0]        lsu_wdata_i,
  output logic [31:0]        lsu_rdata_o,
  output logic               lsu_stall_o,
  output logic               lsu_misalign_o,
  output logic               lsu_fault_o,
  miriscv_lsu_ctrl_if.master bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
  state_e state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [29:0]      addr_reg;
  logic             we_reg;
  logic [3:0]       be_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      rdata_reg;
  logic [1:0]       off_reg;
  logic             word_reg, half_reg, uns_reg;
  logic             fault_reg;

  logic capture, load_done, fault_set, timeout, trap;

  // Sizes 3/6/7 fold into W; the unsigned flag is only consulted on loads
  logic        is_word, is_half, is_uns;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  assign is_word   = lsu_size_i[1];
  assign is_half   = ~lsu_size_i[1] & lsu_size_i[0];
  assign is_uns    = lsu_size_i[2] & ~lsu_size_i[1];
  assign off       = is_word ? 2'b00 : (is_half ? {lsu_addr_i[1], 1'b0} : lsu_addr_i[1:0]);
  assign be        = is_word ? 4'b1111 : (is_half ? (4'b0011 << off) : (4'b0001 << off));
  assign wdata_rep = is_word ? lsu_wdata_i
                   : (is_half ? {2{lsu_wdata_i[15:0]}} : {4{lsu_wdata_i[7:0]}});

`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
  logic misalign_reg;
  assign trap = (is_half & lsu_addr_i[0]) | (is_word & (lsu_addr_i[1:0] != 2'b00));
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) misalign_reg <= 1'b0;
    else          misalign_reg <= (state_reg == IDLE) & lsu_req_i & trap;
  end
  assign lsu_misalign_o = misalign_reg;
`else
  assign trap           = 1'b0;
  assign lsu_misalign_o = 1'b0;
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign timeout = (32'(cnt_reg) == 32'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // A grant or response in the last allowed wait cycle still wins over the timeout
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    load_done  = 1'b0;
    fault_set  = 1'b0;
    case (state_reg)
      IDLE: if (lsu_req_i) begin
        if (trap) state_next = DONE;
        else begin
          state_next = REQ;
          capture    = 1'b1;
        end
      end
      REQ: if (bus.data_gnt_i) state_next = RESP;
           else if (timeout) begin
             state_next = DONE;
             fault_set  = 1'b1;
           end
      RESP: if (bus.data_rvalid_i) begin
              state_next = DONE;
              load_done  = ~we_reg;
            end else if (timeout) begin
              state_next = DONE;
              fault_set  = 1'b1;
            end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [31:0] shifted, load_ext;
  assign shifted = bus.data_rdata_i >> {off_reg, 3'b000};
  always_comb begin
    if (word_reg)      load_ext = shifted;
    else if (half_reg) load_ext = {{16{~uns_reg & shifted[15]}}, shifted[15:0]};
    else               load_ext = {{24{~uns_reg & shifted[7]}}, shifted[7:0]};
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_reg   <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      be_reg    <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      off_reg   <= '0;
      word_reg  <= 1'b0;
      half_reg  <= 1'b0;
      uns_reg   <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      if (capture) begin
        addr_reg  <= lsu_addr_i[31:2];
        we_reg    <= lsu_we_i;
        be_reg    <= be;
        wdata_reg <= wdata_rep;
        off_reg   <= off;
        word_reg  <= is_word;
        half_reg  <= is_half;
        uns_reg   <= is_uns;
      end
      if (load_done) rdata_reg <= load_ext;
      fault_reg <= fault_set;
      // Cleared on every state change, so it counts wait cycles from entry into REQ or RESP
      if (state_next != state_reg) cnt_reg <= '0;
      else                         cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.data_req_o   = (state_reg == REQ);
  assign bus.data_we_o    = we_reg;
  assign bus.data_be_o    = be_reg;
  assign bus.data_addr_o  = {addr_reg, 2'b00};
  assign bus.data_wdata_o = wdata_reg;
  assign lsu_rdata_o      = rdata_reg;
  assign lsu_fault_o      = fault_reg;
  assign lsu_stall_o      = lsu_req_i & (state_reg != DONE);
endmodule

// File: tb/tb_miriscv_lsu_ctrl.sv
// Randomized bench for miriscv_lsu_ctrl: reactive bus responder plus a per-cycle compare
// against a transaction-level model of bus fields, stall length, flags and load results.
`timescale 1ns/1ps
module tb_miriscv_lsu_ctrl;
  localparam int T = 4;
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arstn;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_stall, lsu_misalign, lsu_fault;

  miriscv_lsu_ctrl_if bus();

  miriscv_lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .lsu_req_i      (lsu_req),
    .lsu_we_i       (lsu_we),
    .lsu_size_i     (lsu_size),
    .lsu_addr_i     (lsu_addr),
    .lsu_wdata_i    (lsu_wdata),
    .lsu_rdata_o    (lsu_rdata),
    .lsu_stall_o    (lsu_stall),
    .lsu_misalign_o (lsu_misalign),
    .lsu_fault_o    (lsu_fault),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expectations for the transaction in flight (cycle idx 0 = the IDLE cycle it is presented)
  bit          in_txn = 1'b0;
  bit          cmp_en = 1'b0;
  int          idx;
  int          cur_n, cur_hi;
  bit          cur_fault, cur_mis, cur_load_ok, cur_we;
  logic [31:0] cur_addr, cur_wdata, cur_load;
  logic [3:0]  cur_be;
  logic [31:0] rdata_model = 32'h0;

  int          stall_seen, req_seen, fault_seen, mis_seen;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic model(input bit we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int gd, input int rd);
    int nb, a, off;
    bit uns, mis, trap;
    longint v, lim;
    case (size)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      default:    nb = 4;
    endcase
    uns  = (size == 3'd4) || (size == 3'd5);
    a    = int'(addr % 4);
    mis  = (a % nb) != 0;
    off  = a - (a % nb);
    trap = TRAP_EN && mis;
    cur_we   = we;
    cur_addr = addr - 32'(a);
    cur_be   = 4'(((1 << nb) - 1) << off);
    case (nb)
      1:       cur_wdata = (wdata & 32'hFF) * 32'h0101_0101;
      2:       cur_wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
      default: cur_wdata = wdata;
    endcase
    lim = longint'(1) << (8 * nb);
    v   = longint'(rdata >> (8 * off)) % lim;
    if (!uns && nb < 4 && v >= lim / 2) v = v - lim;
    cur_load    = v[31:0];
    cur_mis     = trap;
    cur_fault   = 1'b0;
    cur_load_ok = 1'b0;
    if (trap) begin
      cur_n = 1; cur_hi = 0;
    end else if (gd >= T) begin
      cur_n = 1 + T; cur_hi = T; cur_fault = 1'b1;
    end else if (rd >= T) begin
      cur_n = 2 + gd + T; cur_hi = 1 + gd; cur_fault = 1'b1;
    end else begin
      cur_n = 3 + gd + rd; cur_hi = 1 + gd; cur_load_ok = !we;
    end
  endtask

  // Called at posedge+2; returns at posedge+2 of the cycle after DONE
  task automatic run_txn(input bit we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int gd, input int rd, input bit early);
    int reqcnt  = 0;
    int respcnt = 0;
    bit granted = 1'b0;
    model(we, size, addr, wdata, rdata, gd, rd);
    stall_seen = 0; req_seen = 0; fault_seen = 0; mis_seen = 0;
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = $urandom;
    idx = 0; in_txn = 1'b1;
    while (1) begin
      @(posedge clk); #2;
      idx++;
      if (idx > cur_n) break;
      bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = $urandom;
      if (bus.data_req_o) begin
        if (reqcnt == gd) begin
          bus.data_gnt_i = 1'b1;
          granted = 1'b1;
          if (early) bus.data_rvalid_i = 1'b1;
        end
        reqcnt++;
      end else if (granted) begin
        if (respcnt == rd) begin
          bus.data_rvalid_i = 1'b1;
          bus.data_rdata_i  = rdata;
        end
        respcnt++;
      end
    end
    in_txn = 1'b0;
    lsu_req = 1'b0;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      lsu_req = 1'b0;
      bus.data_gnt_i = 1'b0;
      bus.data_rvalid_i = ($urandom_range(0, 1) == 1);
      bus.data_rdata_i = $urandom;
      @(posedge clk); #2;
    end
    bus.data_rvalid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rdata"}, lsu_rdata, 32'h0);
    chk({tag, "_stall"}, lsu_stall, 32'h0);
    chk({tag, "_mis"},   lsu_misalign, 32'h0);
    chk({tag, "_fault"}, lsu_fault, 32'h0);
    chk({tag, "_req"},   bus.data_req_o, 32'h0);
    chk({tag, "_we"},    bus.data_we_o, 32'h0);
    chk({tag, "_be"},    bus.data_be_o, 32'h0);
    chk({tag, "_addr"},  bus.data_addr_o, 32'h0);
    chk({tag, "_wdata"}, bus.data_wdata_o, 32'h0);
  endtask

  task automatic rst_mid(input bit in_resp);
    cmp_en = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h40; lsu_wdata = 32'h0;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
    @(posedge clk); #2;
    chk("rst_req_before", bus.data_req_o, 32'h1);
    if (in_resp) begin
      bus.data_gnt_i = 1'b1;
      @(posedge clk); #2;
      bus.data_gnt_i = 1'b0;
      chk("rst_stall_in_resp", lsu_stall, 32'h1);
    end
    arstn = 1'b0; lsu_req = 1'b0;
    #1;
    check_all_zero(in_resp ? "rst_resp" : "rst_req");
    @(negedge clk);
    arstn = 1'b1;
    rdata_model = 32'h0;
    @(posedge clk); #2;
    cmp_en = 1'b1;
  endtask

  // Per-cycle compare against the model
  bit e_stall, e_req, e_done;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e_stall = in_txn && (idx < cur_n);
        e_req   = in_txn && (idx >= 1) && (idx <= cur_hi);
        e_done  = in_txn && (idx == cur_n);
        if (e_done && cur_load_ok) rdata_model = cur_load;
        chk("stall",    lsu_stall, 32'(e_stall));
        chk("req",      bus.data_req_o, 32'(e_req));
        chk("misalign", lsu_misalign, 32'(e_done && cur_mis));
        chk("fault",    lsu_fault, 32'(e_done && cur_fault));
        chk("rdata",    lsu_rdata, rdata_model);
        if (e_req) begin
          chk("bus_addr",  bus.data_addr_o, cur_addr);
          chk("bus_we",    bus.data_we_o, 32'(cur_we));
          chk("bus_be",    bus.data_be_o, 32'(cur_be));
          chk("bus_wdata", bus.data_wdata_o, cur_wdata);
        end
        if (lsu_stall)    stall_seen++;
        if (lsu_fault)    fault_seen++;
        if (lsu_misalign) mis_seen++;
        if (bus.data_req_o) begin
          req_seen++;
          last_addr = bus.data_addr_o; last_be = bus.data_be_o;
          last_wdata = bus.data_wdata_o; last_we = bus.data_we_o;
        end
      end
    end
  end

  bit          r_we, r_early;
  logic [2:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  int          r_gd, r_rd;

  initial begin
    arstn = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 3'd0;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    arstn = 1'b1;
    @(posedge clk); #2;
    cmp_en = 1'b1;

    run_txn(1'b0, 3'd0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0);
    chk("lb_rdata", lsu_rdata, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(stall_seen), 32'd3);
    chk("lb_be", 32'(last_be), 32'h8);
    chk("lb_addr", last_addr, 32'h1000);

    run_txn(1'b1, 3'd1, 32'h2002, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 1'b0);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(last_we), 32'h1);
    chk("sh_rdata_kept", lsu_rdata, 32'hFFFF_FF80);

    run_txn(1'b0, 3'd5, 32'h0002, 32'h0, 32'hF00D_0000, 2, 1, 1'b0);
    chk("lhu_rdata", lsu_rdata, 32'h0000_F00D);
    chk("lhu_stall_cycles", 32'(stall_seen), 32'd6);
    chk("lhu_req_cycles", 32'(req_seen), 32'd3);

    run_txn(1'b0, 3'd2, 32'h0001, 32'h0, 32'hCAFE_BABE, 0, 0, 1'b0);
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    chk("lw_mis_pulse", 32'(mis_seen), 32'd1);
    chk("lw_mis_noreq", 32'(req_seen), 32'd0);
    chk("lw_mis_stall", 32'(stall_seen), 32'd1);
    chk("lw_mis_rdata", lsu_rdata, 32'h0000_F00D);
`else
    chk("lw_mis_addr", last_addr, 32'h0);
    chk("lw_mis_be", 32'(last_be), 32'hF);
    chk("lw_mis_rdata", lsu_rdata, 32'hCAFE_BABE);
`endif

    run_txn(1'b0, 3'd2, 32'h0100, 32'h0, 32'h1111_1111, 99, 0, 1'b0);
    chk("to_req_cycles", 32'(req_seen), 32'd4);
    chk("to_fault_pulse", 32'(fault_seen), 32'd1);
    chk("to_stall_cycles", 32'(stall_seen), 32'd5);

    rst_mid(1'b1);
    run_txn(1'b0, 3'd1, 32'h0010, 32'h0, 32'h1234_8001, 0, 0, 1'b0);
    chk("post_rst_lh", lsu_rdata, 32'hFFFF_8001);
    rst_mid(1'b0);

    for (int i = 0; i < 400; i++) begin
      r_we    = ($urandom_range(0, 1) == 1);
      r_size  = 3'($urandom_range(0, 7));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_gd    = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, 3);
      r_rd    = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, 3);
      r_early = ($urandom_range(0, 3) == 0);
      run_txn(r_we, r_size, r_addr, r_wdata, r_rdata, r_gd, r_rd, r_early);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
